// File: rtl/mul_ex_pipe.sv
// mul_ex_pipe: two-stage pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) for the
// long-latency integer lanes. EX1 forms two partial products from the extended operands,
// EX2 sums them and selects the low or high result word. The result is presented to the
// commit/CDB stage with a valid/grant handshake; a full flush kills every in-flight op.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_v       issue valid from the forwarding stage
//   in_rdy     unit can accept an issue this cycle (combinational)
//   in_src1    rs1 operand
//   in_src2    rs2 operand
//   in_robid   destination robid
//   in_func3   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU (bit 2 ignored)
//   flush      kill every in-flight op
//   out_v      result valid toward CDB/CMT
//   out_robid  robid of the presented result
//   out_data   presented result
//   cdb_gnt    CDB accepts out_* this cycle
module mul_ex_pipe #(
  parameter int unsigned DATA_LEN  = 32,
  parameter int unsigned ROBID_LEN = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_v,
  output logic                 in_rdy,
  input  logic [DATA_LEN-1:0]  in_src1,
  input  logic [DATA_LEN-1:0]  in_src2,
  input  logic [ROBID_LEN-1:0] in_robid,
  input  logic [2:0]           in_func3,
  input  logic                 flush,
  output logic                 out_v,
  output logic [ROBID_LEN-1:0] out_robid,
  output logic [DATA_LEN-1:0]  out_data,
  input  logic                 cdb_gnt
);

  // Operands are extended by one bit so that signed and unsigned forms share one multiplier.
  localparam int unsigned ExtW  = DATA_LEN + 1;
  localparam int unsigned LoW   = DATA_LEN / 2;
  localparam int unsigned HiW   = ExtW - LoW;
  localparam int unsigned PpW   = ExtW + HiW;
  localparam int unsigned ProdW = 2 * DATA_LEN;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic v1_q, v1_d;
  logic out_v_q, out_v_d;
  logic adv1, adv2;

  assign adv2   = ~out_v_q | cdb_gnt;
  assign adv1   = ~v1_q | adv2;
  assign in_rdy = adv1;

  // ---------------------------------------------------------------------------
  // EX1: operand extension and partial products
  // ---------------------------------------------------------------------------
  logic            a_msb, b_msb;
  logic [ExtW-1:0] a_ext, b_ext;
  logic [PpW-1:0]  a_wide, b_lo_wide, b_hi_wide;
  logic [PpW-1:0]  ppl_d, pph_d;

  always_comb begin
    // rs1 is unsigned only for MULHU; rs2 is unsigned for MULHSU and MULHU.
    a_msb     = (in_func3[1:0] != 2'b11) & in_src1[DATA_LEN-1];
    b_msb     = ~in_func3[1] & in_src2[DATA_LEN-1];
    a_ext     = {a_msb, in_src1};
    b_ext     = {b_msb, in_src2};
    // All factors are widened to the product width, so a plain modular multiply yields the
    // exact two's-complement product bits.
    a_wide    = {{(PpW - ExtW){a_ext[ExtW-1]}}, a_ext};
    b_lo_wide = {{(PpW - LoW){1'b0}}, b_ext[LoW-1:0]};
    b_hi_wide = {{(PpW - HiW){b_ext[ExtW-1]}}, b_ext[ExtW-1:LoW]};
    ppl_d     = a_wide * b_lo_wide;
    pph_d     = a_wide * b_hi_wide;
  end

  logic [ROBID_LEN-1:0] robid1_q, robid1_d;
  logic [1:0]           func1_q, func1_d;
  logic [PpW-1:0]       ppl_q, pph_q;
  logic [PpW-1:0]       ppl_n, pph_n;

  always_comb begin
    v1_d     = v1_q;
    robid1_d = robid1_q;
    func1_d  = func1_q;
    ppl_n    = ppl_q;
    pph_n    = pph_q;
    if (adv1) begin
      v1_d     = in_v;
      robid1_d = in_robid;
      func1_d  = in_func3[1:0];
      ppl_n    = ppl_d;
      pph_n    = pph_d;
    end
    // A flush discards the contents and any same-cycle issue.
    if (flush) begin
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      robid1_q <= '0;
      func1_q  <= '0;
      ppl_q    <= '0;
      pph_q    <= '0;
    end else begin
      v1_q     <= v1_d;
      robid1_q <= robid1_d;
      func1_q  <= func1_d;
      ppl_q    <= ppl_n;
      pph_q    <= pph_n;
    end
  end

  // ---------------------------------------------------------------------------
  // EX2: partial-product sum and result selection
  // ---------------------------------------------------------------------------
  logic [ProdW-1:0]    prod;
  logic [DATA_LEN-1:0] res;

  always_comb begin
    // Only the low 64 bits of the sum matter, so the shifted high partial is truncated.
    prod = {{(ProdW - PpW){ppl_q[PpW-1]}}, ppl_q}
         + {pph_q[ProdW-LoW-1:0], {LoW{1'b0}}};
    res  = (func1_q == 2'b00) ? prod[DATA_LEN-1:0] : prod[ProdW-1:DATA_LEN];
  end

  logic [ROBID_LEN-1:0] out_robid_q, out_robid_d;
  logic [DATA_LEN-1:0]  out_data_q, out_data_d;

  always_comb begin
    out_v_d     = out_v_q;
    out_robid_d = out_robid_q;
    out_data_d  = out_data_q;
    if (adv2) begin
      out_v_d     = v1_q;
      out_robid_d = robid1_q;
      out_data_d  = res;
    end
    if (flush) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q     <= 1'b0;
      out_robid_q <= '0;
      out_data_q  <= '0;
    end else begin
      out_v_q     <= out_v_d;
      out_robid_q <= out_robid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_v     = out_v_q;
  assign out_robid = out_robid_q;
  assign out_data  = out_data_q;

  // func3 bit 2 and the partial-product bits shifted past the 64-bit product are don't-care.
  logic unused_bits;
  assign unused_bits = ^{in_func3[2], pph_q[PpW-1:ProdW-LoW]};

endmodule

// File: tb/tb_mul_ex_pipe.sv
module tb_mul_ex_pipe;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_v;
  logic          in_rdy;
  logic [DW-1:0] in_src1;
  logic [DW-1:0] in_src2;
  logic [RW-1:0] in_robid;
  logic [2:0]    in_func3;
  logic          flush;
  logic          out_v;
  logic [RW-1:0] out_robid;
  logic [DW-1:0] out_data;
  logic          cdb_gnt;

  always #5 clk = ~clk;

  mul_ex_pipe #(.DATA_LEN(DW), .ROBID_LEN(RW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_v     (in_v),
    .in_rdy   (in_rdy),
    .in_src1  (in_src1),
    .in_src2  (in_src2),
    .in_robid (in_robid),
    .in_func3 (in_func3),
    .flush    (flush),
    .out_v    (out_v),
    .out_robid(out_robid),
    .out_data (out_data),
    .cdb_gnt  (cdb_gnt)
  );

  // Reference model: an in-order list of accepted ops, each tagged with the number of clock
  // edges it has spent in the unit. The oldest op is visible once it has seen one edge.
  typedef struct {
    logic [RW-1:0] robid;
    logic [DW-1:0] data;
    int            age;
  } op_t;

  op_t q[$];
  int  total = 0;
  int  bad = 0;
  int  drops = 0;
  int  n_ret = 0;
  int  run = 0;
  int  max_run = 0;
  bit  retired [0:63];

  function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f[1:0] == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = f[1] ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [RW-1:0] r, input logic fl,
                       input logic g);
    @(posedge clk);
    #1;
    in_v     = v;
    in_func3 = f;
    in_src1  = a;
    in_src2  = b;
    in_robid = r;
    flush    = fl;
    cdb_gnt  = g;
  endtask

  task automatic idle(input int n, input logic g);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, g);
  endtask

  task automatic clear_retired();
    for (int i = 0; i < 64; i++) retired[i] = 1'b0;
  endtask

  // Issue one op with cdb_gnt held high and check its result against literal values.
  task automatic directed(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [RW-1:0] r,
                          input logic [31:0] exp);
    int lat;
    lat = 0;
    drive(1'b1, f, a, b, r, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, 1'b1);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (out_v) begin
        lat = n;
        break;
      end
    end
    chk({name, "_latency"}, lat, 2);
    chk({name, "_robid"}, out_robid, r);
    chk({name, "_data"}, out_data, exp);
  endtask

  // Compare process: every cycle, outputs against the model, then advance the model.
  always @(negedge clk) begin : compare
    logic exp_v;
    logic exp_rdy;
    op_t  t;
    if (!rst_n) begin
      q.delete();
      run = 0;
      chk("reset_out_v", out_v, 0);
      chk("reset_in_rdy", in_rdy, 1);
      chk("reset_out_robid", out_robid, 0);
      chk("reset_out_data", out_data, 0);
    end else begin
      exp_v   = (q.size() > 0) && (q[0].age >= 1);
      exp_rdy = (q.size() < 2) || cdb_gnt;
      chk("out_v", out_v, exp_v);
      chk("in_rdy", in_rdy, exp_rdy);
      if (exp_v && out_v) begin
        chk("out_robid", out_robid, q[0].robid);
        chk("out_data", out_data, q[0].data);
      end
      if (out_v) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (out_v && cdb_gnt) retired[out_robid] = 1'b1;
      if (exp_v && cdb_gnt) begin
        void'(q.pop_front());
        n_ret++;
      end
      for (int i = 0; i < q.size(); i++) begin
        t = q[i];
        t.age++;
        q[i] = t;
      end
      if (flush) begin
        q.delete();
      end else if (in_v) begin
        if (exp_rdy) begin
          t.robid = in_robid;
          t.data  = ref_mul(in_func3, in_src1, in_src2);
          t.age   = 0;
          q.push_back(t);
        end else begin
          drops++;
          if (drops <= 8) $display("note: issue robid=%0d dropped, unit not ready", in_robid);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t want <200000", $time);
    $fatal(1);
  end

  initial begin : main
    int d0;
    int n0;
    rst_n    = 1'b0;
    in_v     = 1'b1;
    in_src1  = 32'h1234;
    in_src2  = 32'h5678;
    in_robid = 6'd7;
    in_func3 = 3'd0;
    flush    = 1'b0;
    cdb_gnt  = 1'b1;
    clear_retired();

    // Pin the model against hand-computed values.
    chk("model_mul_7x6", ref_mul(3'b000, 32'd7, 32'd6), 32'h0000_002A);
    chk("model_mulh_min", ref_mul(3'b001, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("model_mulhu_ones", ref_mul(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("model_mulhsu_ones", ref_mul(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("model_mul_ones", ref_mul(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0001);
    chk("model_func_bit2", ref_mul(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

    // Reset held with in_v asserted.
    repeat (2) @(negedge clk);
    #1;
    chk("reset_hold_out_v", out_v, 0);
    chk("reset_hold_in_rdy", in_rdy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_v  = 1'b0;

    directed("mul_7x6", 3'b000, 32'd7, 32'd6, 6'd5, 32'h0000_002A);
    directed("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 6'd6, 32'h4000_0000);
    directed("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7, 32'hFFFF_FFFE);
    directed("mulhsu_ones", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd8, 32'hFFFF_FFFF);
    directed("mul_ones", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4, 32'h0000_0001);

    // Back-pressure: third consecutive issue hits a full pipe and is dropped.
    clear_retired();
    d0 = drops;
    drive(1'b1, 3'b000, 32'd3, 32'd4, 6'd1, 1'b0, 1'b0);
    drive(1'b1, 3'b011, 32'hFFFF_FFFF, 32'd2, 6'd2, 1'b0, 1'b0);
    drive(1'b1, 3'b000, 32'd5, 32'd5, 6'd3, 1'b0, 1'b0);
    #1;
    chk("bp_in_rdy_low", in_rdy, 0);
    chk("bp_out_v", out_v, 1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, 1'b0);
    chk("bp_drop_flagged", drops - d0, 1);
    chk("bp_hold_robid", out_robid, 1);
    chk("bp_hold_data", out_data, 32'd12);
    drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, 1'b1);
    chk("bp_first_v", out_v, 1);
    chk("bp_first_robid", out_robid, 1);
    chk("bp_first_data", out_data, 32'd12);
    drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, 1'b1);
    chk("bp_second_v", out_v, 1);
    chk("bp_second_robid", out_robid, 2);
    chk("bp_second_data", out_data, 32'd1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, 1'b1);
    chk("bp_drain_v", out_v, 0);
    chk("bp_robid3_never", retired[3], 0);

    // Back-to-back streaming.
    idle(2, 1'b1);
    n0      = n_ret;
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 6'(16 + i), 1'b0, 1'b1);
    end
    idle(4, 1'b1);
    chk("stream_count", n_ret - n0, 16);
    chk("stream_run", max_run, 16);

    // Flush with 9 in EX2, 10 in EX1 and 11 issued in the same cycle.
    clear_retired();
    drive(1'b1, 3'b000, rnd_opnd(), rnd_opnd(), 6'd9, 1'b0, 1'b0);
    drive(1'b1, 3'b001, rnd_opnd(), rnd_opnd(), 6'd10, 1'b0, 1'b0);
    drive(1'b1, 3'b011, rnd_opnd(), rnd_opnd(), 6'd11, 1'b1, 1'b0);
    chk("flush_pre_robid", out_robid, 9);
    drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, 1'b0);
    chk("flush_out_v", out_v, 0);
    idle(4, 1'b1);
    chk("flush_no_9", retired[9], 0);
    chk("flush_no_10", retired[10], 0);
    chk("flush_no_11", retired[11], 0);

    // Flush and grant together: presented result is still accepted.
    drive(1'b1, 3'b000, 32'd9, 32'd9, 6'd12, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b1, 1'b1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, 1'b1);
    chk("flush_gnt_retired", retired[12], 1);
    chk("flush_gnt_out_v", out_v, 0);

    // Random traffic with stalls and occasional flushes.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
            6'($urandom_range(0, 63)), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 2) != 0));
    end
    idle(4, 1'b1);

    // Asynchronous reset between edges while a result is held.
    drive(1'b1, 3'b000, 32'd9, 32'd9, 6'd20, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, 1'b0);
    chk("areset_pre_out_v", out_v, 1);
    chk("areset_pre_data", out_data, 32'd81);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_out_v", out_v, 0);
    chk("areset_out_robid", out_robid, 0);
    chk("areset_out_data", out_data, 0);
    chk("areset_in_rdy", in_rdy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3, 1'b1);
    chk("areset_after_out_v", out_v, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
